// File: rtl/mm_capture_writer.sv
// Capture engine: serialises 256-bit line writes into {address, word} entries held in a FWFT buffer.
// Latency: first entry visible 2 cycles after accept; stalls (never drops) when the buffer is full.
module mm_capture_writer #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 256,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       mm_wr,
  input  logic [ADDR_W-1:0]          mm_wr_addr,
  input  logic [LINE_W-1:0]          mm_wr_data,
  output logic                       mm_wr_ready,
  output logic                       busy,
  output logic                       rd_valid,
  output logic [ADDR_W-1:0]          rd_addr,
  output logic [WORD_W-1:0]          rd_data,
  input  logic                       rd_pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                lines_captured
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int NB  = LINE_W / WORD_W;
  localparam int BW  = $clog2(NB);
  localparam int OFS = $clog2(LINE_W / 8);
  localparam int WOF = $clog2(WORD_W / 8);

  typedef enum logic {IDLE, SER} state_t;

  state_t                      state_q, state_d;
  logic [BW-1:0]               beat_q, beat_d;
  logic [ADDR_W-1:0]           base_q, base_d;
  logic [NB-1:0][WORD_W-1:0]   line_q, line_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic [15:0]                 lines_q, lines_d;
  logic [ADDR_W+WORD_W-1:0]    mem_q [DEPTH];

  logic                        accept, push, pop;
  logic [ADDR_W-1:0]           push_addr;
  logic [WORD_W-1:0]           push_data;
  logic [ADDR_W+WORD_W-1:0]    head;
  logic [OFS-1:0]              unused_addr_bits;

  // Byte offset within the line is deliberately dropped.
  assign unused_addr_bits = mm_wr_addr[OFS-1:0];

  always_comb begin
    accept    = (state_q == IDLE) && !clear && mm_wr;
    pop       = rd_pop && (count_q != '0) && !clear;
    push      = (state_q == SER) && !clear && ((count_q < CW'(DEPTH)) || pop);
    push_addr = base_q + ADDR_W'({beat_q, {WOF{1'b0}}});
    push_data = line_q[beat_q];

    state_d  = state_q;
    beat_d   = beat_q;
    base_d   = base_q;
    line_d   = line_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    lines_d  = lines_q;

    if (clear) begin
      state_d  = IDLE;
      beat_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) begin
        base_d  = {mm_wr_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
        line_d  = mm_wr_data;
        beat_d  = '0;
        state_d = SER;
        if (lines_q != 16'hFFFF) lines_d = lines_q + 16'd1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        beat_d   = beat_q + BW'(1);
        if (beat_q == BW'(NB - 1)) state_d = IDLE;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      base_q   <= '0;
      line_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      lines_q  <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      base_q   <= base_d;
      line_q   <= line_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lines_q  <= lines_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_addr, push_data};
  end

  always_comb begin
    head           = mem_q[rd_ptr_q];
    rd_valid       = (count_q != '0);
    rd_addr        = rd_valid ? head[ADDR_W+WORD_W-1:WORD_W] : '0;
    rd_data        = rd_valid ? head[WORD_W-1:0] : '0;
    mm_wr_ready    = (state_q == IDLE) && !clear;
    busy           = (state_q == SER);
    count          = count_q;
    lines_captured = lines_q;
  end

endmodule

// File: tb/tb_mm_capture_writer.sv
// Directed bench for mm_capture_writer: hand-computed entries, stall, clear and async reset cases.
module tb_mm_capture_writer;

  logic         clk = 1'b0;
  logic         reset, clear, mm_wr, rd_pop;
  logic [31:0]  mm_wr_addr;
  logic [255:0] mm_wr_data;
  logic         mm_wr_ready, busy, rd_valid;
  logic [31:0]  rd_addr, rd_data;
  logic [4:0]   count;
  logic [15:0]  lines_captured;

  int n_vec = 0;
  int n_err = 0;

  mm_capture_writer dut (
    .clk(clk), .reset(reset), .clear(clear), .mm_wr(mm_wr),
    .mm_wr_addr(mm_wr_addr), .mm_wr_data(mm_wr_data), .mm_wr_ready(mm_wr_ready),
    .busy(busy), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_pop(rd_pop), .count(count), .lines_captured(lines_captured)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_line(input logic [31:0] addr, input logic [31:0] dbase);
    int w = 0;
    while (!mm_wr_ready && w < 100) begin tick(); w++; end
    if (w >= 100) chk("ready_timeout", 64'd0, 64'd1);
    mm_wr      = 1'b1;
    mm_wr_addr = addr;
    for (int i = 0; i < 8; i++) mm_wr_data[32*i +: 32] = dbase + 32'(i);
    tick();
    mm_wr      = 1'b0;
    mm_wr_data = '0;
  endtask

  // Pops entries first..last of a line whose entries are {base+4i, dbase+i}.
  task automatic drain(input logic [31:0] base, input logic [31:0] dbase,
                       input int first, input int last);
    for (int i = first; i <= last; i++) begin
      int w = 0;
      while (!rd_valid && w < 50) begin tick(); w++; end
      if (w >= 50) chk("valid_timeout", 64'd0, 64'd1);
      chk("rd_addr", rd_addr, base + 32'(4 * i));
      chk("rd_data", rd_data, dbase + 32'(i));
      rd_pop = 1'b1;
      tick();
      rd_pop = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_valid"}, rd_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, mm_wr_ready, 1);
    chk({tag, "_lines"}, lines_captured, 0);
    chk({tag, "_addr"}, rd_addr, 0);
    chk({tag, "_data"}, rd_data, 0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; mm_wr = 1'b0; rd_pop = 1'b0;
    mm_wr_addr = '0; mm_wr_data = '0;
    tick(2);
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();

    // Single aligned line, no pops.
    send_line(32'h0000_1000, 32'hA000_0000);
    chk("acc_busy", busy, 1);
    chk("acc_ready", mm_wr_ready, 0);
    chk("acc_lines", lines_captured, 1);
    chk("acc_valid", rd_valid, 0);
    tick();
    chk("first_valid", rd_valid, 1);
    chk("first_cnt", count, 1);
    tick(7);
    chk("peak_cnt", count, 8);
    chk("done_busy", busy, 0);
    chk("done_ready", mm_wr_ready, 1);
    drain(32'h0000_1000, 32'hA000_0000, 0, 7);
    chk("empty_cnt", count, 0);

    // Pop while empty is a no-op.
    rd_pop = 1'b1;
    tick();
    rd_pop = 1'b0;
    chk("pop_empty_cnt", count, 0);
    chk("pop_empty_valid", rd_valid, 0);

    // Misaligned address at the top of memory: no carry out.
    send_line(32'hFFFF_FFF4, 32'hB000_0000);
    tick(8);
    chk("wrap_cnt", count, 8);
    drain(32'hFFFF_FFE0, 32'hB000_0000, 0, 7);
    chk("wrap_lines", lines_captured, 2);

    // Three back-to-back lines without pops: buffer fills, line 3 stalls on beat 0.
    send_line(32'h0000_2000, 32'hD000_0000);
    send_line(32'h0000_3000, 32'hD100_0000);
    send_line(32'h0000_4000, 32'hD200_0000);
    tick(3);
    chk("full_cnt", count, 16);
    chk("full_busy", busy, 1);
    chk("full_ready", mm_wr_ready, 0);
    chk("full_head", rd_addr, 32'h0000_2000);
    // Pop on the stalled cycle: push proceeds on the same edge.
    rd_pop = 1'b1;
    tick();
    rd_pop = 1'b0;
    chk("simul_cnt", count, 16);
    chk("simul_head", rd_addr, 32'h0000_2004);
    drain(32'h0000_2000, 32'hD000_0000, 1, 7);
    drain(32'h0000_3000, 32'hD100_0000, 0, 7);
    drain(32'h0000_4000, 32'hD200_0000, 0, 7);
    chk("stall_empty", count, 0);
    chk("stall_lines", lines_captured, 5);
    chk("stall_busy", busy, 0);

    // Clear after three beats.
    send_line(32'h0000_5000, 32'hE000_0000);
    tick(3);
    chk("pre_clr_cnt", count, 3);
    clear = 1'b1;
    #1;
    chk("clr_ready", mm_wr_ready, 0);
    tick();
    clear = 1'b0;
    #1;
    chk("clr_cnt", count, 0);
    chk("clr_valid", rd_valid, 0);
    chk("clr_busy", busy, 0);
    chk("clr_ready_after", mm_wr_ready, 1);
    chk("clr_lines", lines_captured, 6);
    send_line(32'h0000_6000, 32'hF000_0000);
    tick(8);
    chk("post_clr_cnt", count, 8);
    drain(32'h0000_6000, 32'hF000_0000, 0, 7);

    // Async reset after five beats, between clock edges.
    send_line(32'h0000_7000, 32'h7700_0000);
    tick(5);
    chk("pre_rst_cnt", count, 5);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("arst");
    #1;
    reset = 1'b0;
    tick();
    send_line(32'h0000_8000, 32'h1100_0000);
    tick(8);
    chk("post_rst_cnt", count, 8);
    chk("post_rst_lines", lines_captured, 1);
    drain(32'h0000_8000, 32'h1100_0000, 0, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mm_capture_writer.md
Name: mm_capture_writer

Overview:
- Bench-side capture engine on the cache-to-main-memory write path (evicts and flushes).
- Serialises each 256-bit line write into eight 32-bit {address, data} word entries.
- Holds the entries in a 16-deep first-word-fall-through buffer, which the testbench drains to fill its actual-capture address/data arrays for comparison against expected main-memory traffic.
- It is the writer for the capture arrays that the bench and probes read.

Parameters:
- ADDR_W, 32, byte address width.
- WORD_W, 32, captured word width.
- LINE_W, 256, cache line width (8 words).
- DEPTH, 16, capture buffer entries (power of two).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of buffer and serialiser.
- mm_wr  in  1  line write strobe from the cache to main memory.
- mm_wr_addr  in  ADDR_W  line byte address.
- mm_wr_data  in  LINE_W  line data; word i is bits [32i+31:32i].
- mm_wr_ready  out  1  capture can accept a line this cycle.
- busy  out  1  serialiser active.
- rd_valid  out  1  buffer non-empty; head entry presented.
- rd_addr  out  ADDR_W  head entry address.
- rd_data  out  WORD_W  head entry data.
- rd_pop  in  1  consume head entry; ignored when rd_valid=0.
- count  out  log2(DEPTH)+1  entries held, 0..DEPTH.
- lines_captured  out  16  accepted lines, saturates at 16'hFFFF.

Behaviour:
- Reset values: state IDLE, count 0, rd_valid 0, busy 0, lines_captured 0, rd_addr/rd_data 0, mm_wr_ready 1.
- State machine, two states:
  - IDLE: mm_wr_ready = !clear.
  - SER: mm_wr_ready = 0, busy = 1.
- Accept: mm_wr && mm_wr_ready at a clock edge.
  - Latches base = {mm_wr_addr[ADDR_W-1:5], 5'b0}; low 5 address bits are ignored.
  - Latches the full line into a holding register.
  - Sets beat counter to 0, increments lines_captured, moves to SER.
- SER, per beat:
  - Push {base + 4*beat, line[32*beat+31:32*beat]}.
  - Address addition is modulo 2^ADDR_W: base 32'hFFFF_FFE0 yields the last word at 32'hFFFF_FFFC, with no carry out.
- Push is allowed when count < DEPTH, or when count == DEPTH and rd_pop && rd_valid in the same cycle. Otherwise the beat stalls, the beat counter holds and nothing is dropped.
- Beat 7 push completes → IDLE. A new line may be accepted the cycle after returning to IDLE. Minimum line-to-line spacing is 9 cycles; first entry is visible on rd_valid 2 cycles after accept.
- Read side is first-word-fall-through: rd_addr/rd_data reflect the head whenever rd_valid=1.
  - Pop advances the read pointer at the edge.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - Entry order equals push order.
- count: +1 on push only, −1 on pop only; never exceeds DEPTH, never underflows (pop while empty is a no-op).
- clear (synchronous):
  - Highest priority after reset.
  - Empties the buffer (count 0, rd_valid 0) and aborts any serialisation, returning to IDLE with remaining beats discarded.
  - Blocks acceptance that cycle (mm_wr_ready 0).
  - lines_captured is not cleared.
- Reset asserted mid-serialisation: immediate return to reset values; partial line lost.
- mm_wr while mm_wr_ready=0 is ignored. The cache side must hold the request or is treated as dropped; the bench flags it as an error.
- X on mm_wr_data is captured as-is; no checking.

Test Plan:
- Single line: after reset, mm_wr addr 32'h0000_1000, data word i = 32'hA000_0000+i → 8 entries (32'h1000, 32'hA0000000) … (32'h101C, 32'hA0000007) in order; count peaks at 8 with no pops; lines_captured 1.
- Misaligned and wrap: addr 32'hFFFF_FFF4 → base 32'hFFFF_FFE0, entries at FFE0..FFFC; no address carry.
- Full stall: three back-to-back lines with no pops → count stops at 16, beat stalls on line 3 beat 0 with busy=1 and mm_wr_ready=0; then pop one per cycle → all 24 entries drain in order, none lost.
- Simultaneous push/pop at count 16: pop on the stalled cycle → push proceeds the same edge, count stays 16, head advances.
- clear mid-line after 3 beats: count 0 next cycle, state IDLE, mm_wr_ready 1 the following cycle, lines_captured unchanged; a new line captures cleanly.
- Async reset mid-serialisation at beat 5 → all outputs at reset values without a clock edge; a subsequent line captures from beat 0.
